regf_top: RTL and testbench

REGF_TOP -- requirements
Module: regf_top

---
 rtl/regf_top.sv | 74 +++++++
 tb/tb_regf_top.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regf_top.sv
// regf_top: 32x32 bypassed GPR file with exception/iret privilege FSM and special registers.
module regf_top (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_write_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  input  logic        xcpt_valid,
  input  logic [31:0] xcpt_pc,
  input  logic [31:0] xcpt_addr,
  input  logic [1:0]  xcpt_type,
  input  logic        iret_valid,
  input  logic [4:0]  src1_addr,
  input  logic [4:0]  src2_addr,
  output logic [31:0] src1_data,
  output logic [31:0] src2_data,
  input  logic [1:0]  rm_sel,
  output logic [31:0] rm_rd_data,
  output logic        priv_mode,
  output logic [31:0] iret_pc,
  output logic        iret_pc_valid,
  output logic        double_fault
);
  typedef enum logic {USER = 1'b0, SUPER = 1'b1} state_t;
  state_t state, state_nxt;
  logic [31:0] gpr [32];
  logic [31:0] rm0, rm1;
  logic [1:0]  rm2;
  logic        wr, xcpt_take, iret_go;
  assign wr        = wb_write_en && !xcpt_valid;
  assign xcpt_take = xcpt_valid && state == USER;
  assign iret_go   = iret_valid && !xcpt_valid && state == SUPER;
  assign src1_data = (wr && wb_dest == src1_addr) ? wb_data : gpr[src1_addr];
  assign src2_data = (wr && wb_dest == src2_addr) ? wb_data : gpr[src2_addr];
  always_ff @(posedge clock) begin
    if (reset)
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    else if (wr)
      gpr[wb_dest] <= wb_data;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= SUPER;
    else       state <= state_nxt;
  end
  // Exception always wins; iret in USER falls through to USER, i.e. is ignored.
  always_comb begin
    state_nxt = xcpt_valid ? SUPER : (iret_valid ? USER : state);
  end
  always_comb begin
    priv_mode = (state == SUPER);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rm0           <= '0;
      rm1           <= '0;
      rm2           <= '0;
      iret_pc       <= '0;
      iret_pc_valid <= 1'b0;
      double_fault  <= 1'b0;
    end else begin
      iret_pc_valid <= iret_go;
      if (iret_go) iret_pc <= rm0;
      if (xcpt_take) begin
        rm0 <= xcpt_pc;
        rm1 <= xcpt_addr;
        rm2 <= xcpt_type;
      end
      if (xcpt_valid && state == SUPER) double_fault <= 1'b1;
    end
  end
  assign rm_rd_data = rm_sel == 2'd0 ? rm0 :
                      rm_sel == 2'd1 ? rm1 :
                      rm_sel == 2'd2 ? {30'b0, rm2} : {31'b0, priv_mode};
endmodule

// File: tb/tb_regf_top.sv
// tb_regf_top: table-driven GPR/bypass vectors plus directed privilege-FSM sequences.
module tb_regf_top;
  logic        clock = 1'b0;
  logic        reset;
  logic        wb_write_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        xcpt_valid;
  logic [31:0] xcpt_pc;
  logic [31:0] xcpt_addr;
  logic [1:0]  xcpt_type;
  logic        iret_valid;
  logic [4:0]  src1_addr, src2_addr;
  logic [31:0] src1_data, src2_data;
  logic [1:0]  rm_sel;
  logic [31:0] rm_rd_data;
  logic        priv_mode;
  logic [31:0] iret_pc;
  logic        iret_pc_valid;
  logic        double_fault;
  int n_cmp = 0;
  int n_bad = 0;

  regf_top dut (
    .clock(clock), .reset(reset),
    .wb_write_en(wb_write_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .xcpt_valid(xcpt_valid), .xcpt_pc(xcpt_pc), .xcpt_addr(xcpt_addr), .xcpt_type(xcpt_type),
    .iret_valid(iret_valid),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .src1_data(src1_data), .src2_data(src2_data),
    .rm_sel(rm_sel), .rm_rd_data(rm_rd_data),
    .priv_mode(priv_mode), .iret_pc(iret_pc), .iret_pc_valid(iret_pc_valid),
    .double_fault(double_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        xv;
    logic [4:0]  s1, s2;
    logic [31:0] e1, e2;
  } vec_t;
  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wb_write_en = 1'b0; wb_dest = '0; wb_data = '0;
    xcpt_valid = 1'b0; xcpt_pc = '0; xcpt_addr = '0; xcpt_type = '0;
    iret_valid = 1'b0; src1_addr = '0; src2_addr = '0; rm_sel = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic xcpt(input logic [31:0] pc, input logic [31:0] addr, input logic [1:0] ty);
    xcpt_valid = 1'b1; xcpt_pc = pc; xcpt_addr = addr; xcpt_type = ty;
    tick();
    xcpt_valid = 1'b0;
  endtask

  task automatic rm_check(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    rm_sel = 2'd0; #1; check("rm0", rm_rd_data, e0);
    rm_sel = 2'd1; #1; check("rm1", rm_rd_data, e1);
    rm_sel = 2'd2; #1; check("rm2", rm_rd_data, e2);
    rm_sel = 2'd0;
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 5'd5,  32'h0,        1'b0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vt[2] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd0,  5'd5,  32'h11111111, 32'hDEADBEEF};
    vt[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 32'h11111111, 32'h0};
    vt[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 5'd31, 32'h0,        32'h0};
    vt[5] = '{1'b0, 5'd31, 32'h0,        1'b0, 5'd31, 5'd0,  32'h0,        32'h11111111};
    vt[6] = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd7,  5'd6,  32'h12345678, 32'h0};
    vt[7] = '{1'b1, 5'd6,  32'hCAFEF00D, 1'b0, 5'd7,  5'd6,  32'h12345678, 32'hCAFEF00D};
    vt[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd6,  5'd7,  32'hCAFEF00D, 32'h12345678};
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_priv", {31'b0, priv_mode}, 32'd1);
    check("rst_df", {31'b0, double_fault}, 32'd0);
    check("rst_ipv", {31'b0, iret_pc_valid}, 32'd0);
    check("rst_iret_pc", iret_pc, 32'h0);
    for (int i = 0; i < 32; i++) begin
      src1_addr = 5'(i); src2_addr = 5'(31 - i); #1;
      check("rst_gpr_p1", src1_data, 32'h0);
      check("rst_gpr_p2", src2_data, 32'h0);
    end
    rm_check(32'h0, 32'h0, 32'h0);
    rm_sel = 2'd3; #1; check("rm_priv", rm_rd_data, 32'd1);
    for (int i = 0; i < 9; i++) begin
      wb_write_en = vt[i].we; wb_dest = vt[i].dest; wb_data = vt[i].data;
      xcpt_valid = vt[i].xv; src1_addr = vt[i].s1; src2_addr = vt[i].s2;
      #1;
      check($sformatf("vec%0d_p1", i), src1_data, vt[i].e1);
      check($sformatf("vec%0d_p2", i), src2_data, vt[i].e2);
      tick();
    end
    idle();
    check("tbl_df_sticky", {31'b0, double_fault}, 32'd1);
    rm_check(32'h0, 32'h0, 32'h0);
    do_reset();
    check("df_cleared", {31'b0, double_fault}, 32'd0);
    iret_valid = 1'b1; tick(); iret_valid = 1'b0;
    check("iret0_priv", {31'b0, priv_mode}, 32'd0);
    check("iret0_ipv", {31'b0, iret_pc_valid}, 32'd1);
    wb_write_en = 1'b1; wb_dest = 5'd3; wb_data = 32'h33; tick(); wb_write_en = 1'b0;
    check("iret0_pulse_end", {31'b0, iret_pc_valid}, 32'd0);
    iret_valid = 1'b1; tick(); iret_valid = 1'b0;
    check("user_iret_ignored", {31'b0, iret_pc_valid}, 32'd0);
    check("user_iret_priv", {31'b0, priv_mode}, 32'd0);
    xcpt(32'h1000, 32'h44, 2'd1);
    check("xcpt1_priv", {31'b0, priv_mode}, 32'd1);
    rm_check(32'h1000, 32'h44, 32'd1);
    iret_valid = 1'b1; tick(); iret_valid = 1'b0;
    check("iret_pc", iret_pc, 32'h1000);
    check("iret_ipv", {31'b0, iret_pc_valid}, 32'd1);
    check("iret_priv", {31'b0, priv_mode}, 32'd0);
    tick();
    check("iret_pulse_one", {31'b0, iret_pc_valid}, 32'd0);
    check("iret_pc_hold", iret_pc, 32'h1000);
    wb_write_en = 1'b1; wb_dest = 5'd3; wb_data = 32'h99; src1_addr = 5'd3;
    xcpt_valid = 1'b1; xcpt_pc = 32'h2004; xcpt_addr = 32'h8000; xcpt_type = 2'd2;
    #1; check("xcpt_no_bypass", src1_data, 32'h33);
    tick(); idle(); src1_addr = 5'd3; #1;
    check("xcpt_r3_kept", src1_data, 32'h33);
    check("xcpt2_priv", {31'b0, priv_mode}, 32'd1);
    check("xcpt2_df", {31'b0, double_fault}, 32'd0);
    rm_check(32'h2004, 32'h8000, 32'd2);
    xcpt(32'hBAD0, 32'hBAD4, 2'd3);
    check("dfault_set", {31'b0, double_fault}, 32'd1);
    check("dfault_priv", {31'b0, priv_mode}, 32'd1);
    rm_check(32'h2004, 32'h8000, 32'd2);
    tick(); tick();
    check("dfault_sticky", {31'b0, double_fault}, 32'd1);
    do_reset();
    check("dfault_reset", {31'b0, double_fault}, 32'd0);
    iret_valid = 1'b1; tick(); iret_valid = 1'b0; tick();
    xcpt_valid = 1'b1; iret_valid = 1'b1; xcpt_pc = 32'h3000;
    tick(); idle();
    check("both_priv", {31'b0, priv_mode}, 32'd1);
    check("both_no_pulse", {31'b0, iret_pc_valid}, 32'd0);
    check("both_rm0", rm_rd_data, 32'h3000);
    iret_valid = 1'b1; tick(); iret_valid = 1'b0;
    xcpt(32'h5000, 32'h0, 2'd0);
    iret_valid = 1'b1; tick(); iret_valid = 1'b0;
    check("pre_rst_ipv", {31'b0, iret_pc_valid}, 32'd1);
    check("pre_rst_pc", iret_pc, 32'h5000);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_cancel_ipv", {31'b0, iret_pc_valid}, 32'd0);
    check("rst_cancel_priv", {31'b0, priv_mode}, 32'd1);
    check("rst_cancel_pc", iret_pc, 32'h0);
    wb_write_en = 1'b1; wb_dest = 5'd9; wb_data = 32'h77; iret_valid = 1'b1; reset = 1'b1;
    tick(); idle(); src1_addr = 5'd9; #1;
    check("rst_ovr_gpr", src1_data, 32'h0);
    check("rst_ovr_priv", {31'b0, priv_mode}, 32'd1);
    check("rst_ovr_ipv", {31'b0, iret_pc_valid}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
